// File: rtl/cpu_axi_arb_pkg.sv
// Shared constants for the cpu_axi_arb 2:1 AXI4 arbiter: FSM state encodings
// and master port indices.
package cpu_axi_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t R_IDLE = 2'd0;
  localparam state_t R_ADDR = 2'd1;
  localparam state_t R_DATA = 2'd2;

  localparam state_t W_IDLE = 2'd0;
  localparam state_t W_XFER = 2'd1;
  localparam state_t W_RESP = 2'd2;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

endpackage

// File: rtl/cpu_axi_arb_rr.sv
// 2-way round-robin picker; i_last is the port granted last on this path.
// Build option ARB_DCACHE_PRIO_EN makes the dcache port win every tie.
module cpu_axi_arb_rr
  import cpu_axi_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_grant,
  output logic       o_valid
);

  assign o_valid = |i_req;

`ifdef ARB_DCACHE_PRIO_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives o_grant and no latch is inferred.
    o_grant = PORT_ICACHE;
    case (i_req)
      2'b10: o_grant = PORT_DCACHE;
      2'b11: begin
`ifdef ARB_DCACHE_PRIO_EN
        o_grant = PORT_DCACHE;
`else
        o_grant = ~i_last;
`endif
      end
      default: o_grant = PORT_ICACHE;
    endcase
  end

endmodule

// File: rtl/cpu_axi_arb.sv
// 2:1 AXI4 arbiter merging icache (inport0) and dcache (inport1) onto one memory
// port; read and write paths are arbitrated independently. Option: ARB_DCACHE_PRIO_EN.
module cpu_axi_arb
  import cpu_axi_arb_pkg::*;
#(
  parameter int ID_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // inport0: icache
  input  logic            inport0_arvalid,
  input  logic [31:0]     inport0_araddr,
  input  logic [ID_W-1:0] inport0_arid,
  input  logic [7:0]      inport0_arlen,
  input  logic [1:0]      inport0_arburst,
  output logic            inport0_arready,
  output logic            inport0_rvalid,
  output logic [31:0]     inport0_rdata,
  output logic [1:0]      inport0_rresp,
  output logic [ID_W-1:0] inport0_rid,
  output logic            inport0_rlast,
  input  logic            inport0_rready,
  input  logic            inport0_awvalid,
  input  logic [31:0]     inport0_awaddr,
  input  logic [ID_W-1:0] inport0_awid,
  input  logic [7:0]      inport0_awlen,
  input  logic [1:0]      inport0_awburst,
  output logic            inport0_awready,
  input  logic            inport0_wvalid,
  input  logic [31:0]     inport0_wdata,
  input  logic [3:0]      inport0_wstrb,
  input  logic            inport0_wlast,
  output logic            inport0_wready,
  output logic            inport0_bvalid,
  output logic [1:0]      inport0_bresp,
  output logic [ID_W-1:0] inport0_bid,
  input  logic            inport0_bready,
  // inport1: dcache
  input  logic            inport1_arvalid,
  input  logic [31:0]     inport1_araddr,
  input  logic [ID_W-1:0] inport1_arid,
  input  logic [7:0]      inport1_arlen,
  input  logic [1:0]      inport1_arburst,
  output logic            inport1_arready,
  output logic            inport1_rvalid,
  output logic [31:0]     inport1_rdata,
  output logic [1:0]      inport1_rresp,
  output logic [ID_W-1:0] inport1_rid,
  output logic            inport1_rlast,
  input  logic            inport1_rready,
  input  logic            inport1_awvalid,
  input  logic [31:0]     inport1_awaddr,
  input  logic [ID_W-1:0] inport1_awid,
  input  logic [7:0]      inport1_awlen,
  input  logic [1:0]      inport1_awburst,
  output logic            inport1_awready,
  input  logic            inport1_wvalid,
  input  logic [31:0]     inport1_wdata,
  input  logic [3:0]      inport1_wstrb,
  input  logic            inport1_wlast,
  output logic            inport1_wready,
  output logic            inport1_bvalid,
  output logic [1:0]      inport1_bresp,
  output logic [ID_W-1:0] inport1_bid,
  input  logic            inport1_bready,
  // memory side
  output logic            outport_arvalid,
  output logic [31:0]     outport_araddr,
  output logic [ID_W-1:0] outport_arid,
  output logic [7:0]      outport_arlen,
  output logic [1:0]      outport_arburst,
  input  logic            outport_arready,
  input  logic            outport_rvalid,
  input  logic [31:0]     outport_rdata,
  input  logic [1:0]      outport_rresp,
  input  logic [ID_W-1:0] outport_rid,
  input  logic            outport_rlast,
  output logic            outport_rready,
  output logic            outport_awvalid,
  output logic [31:0]     outport_awaddr,
  output logic [ID_W-1:0] outport_awid,
  output logic [7:0]      outport_awlen,
  output logic [1:0]      outport_awburst,
  input  logic            outport_awready,
  output logic            outport_wvalid,
  output logic [31:0]     outport_wdata,
  output logic [3:0]      outport_wstrb,
  output logic            outport_wlast,
  input  logic            outport_wready,
  input  logic            outport_bvalid,
  input  logic [1:0]      outport_bresp,
  input  logic [ID_W-1:0] outport_bid,
  output logic            outport_bready
);

  state_t r_rd_state;
  logic   r_rd_owner;
  logic   r_rd_last;
  state_t r_wr_state;
  logic   r_wr_owner;
  logic   r_wr_last;
  logic   r_aw_done;
  logic   r_w_done;

  logic   w_rd_grant;
  logic   w_rd_any;
  logic   w_wr_grant;
  logic   w_wr_any;
  logic   w_aw_hs;
  logic   w_w_last_hs;

  // Owner-selected request fields
  logic            w_own_arvalid;
  logic [31:0]     w_own_araddr;
  logic [ID_W-1:0] w_own_arid;
  logic [7:0]      w_own_arlen;
  logic [1:0]      w_own_arburst;
  logic            w_own_rready;
  logic            w_own_awvalid;
  logic [31:0]     w_own_awaddr;
  logic [ID_W-1:0] w_own_awid;
  logic [7:0]      w_own_awlen;
  logic [1:0]      w_own_awburst;
  logic            w_own_wvalid;
  logic [31:0]     w_own_wdata;
  logic [3:0]      w_own_wstrb;
  logic            w_own_wlast;
  logic            w_own_bready;

  assign w_own_arvalid = r_rd_owner ? inport1_arvalid : inport0_arvalid;
  assign w_own_araddr  = r_rd_owner ? inport1_araddr  : inport0_araddr;
  assign w_own_arid    = r_rd_owner ? inport1_arid    : inport0_arid;
  assign w_own_arlen   = r_rd_owner ? inport1_arlen   : inport0_arlen;
  assign w_own_arburst = r_rd_owner ? inport1_arburst : inport0_arburst;
  assign w_own_rready  = r_rd_owner ? inport1_rready  : inport0_rready;
  assign w_own_awvalid = r_wr_owner ? inport1_awvalid : inport0_awvalid;
  assign w_own_awaddr  = r_wr_owner ? inport1_awaddr  : inport0_awaddr;
  assign w_own_awid    = r_wr_owner ? inport1_awid    : inport0_awid;
  assign w_own_awlen   = r_wr_owner ? inport1_awlen   : inport0_awlen;
  assign w_own_awburst = r_wr_owner ? inport1_awburst : inport0_awburst;
  assign w_own_wvalid  = r_wr_owner ? inport1_wvalid  : inport0_wvalid;
  assign w_own_wdata   = r_wr_owner ? inport1_wdata   : inport0_wdata;
  assign w_own_wstrb   = r_wr_owner ? inport1_wstrb   : inport0_wstrb;
  assign w_own_wlast   = r_wr_owner ? inport1_wlast   : inport0_wlast;
  assign w_own_bready  = r_wr_owner ? inport1_bready  : inport0_bready;

  cpu_axi_arb_rr u_rd_rr (
    .i_req   ({inport1_arvalid, inport0_arvalid}),
    .i_last  (r_rd_last),
    .o_grant (w_rd_grant),
    .o_valid (w_rd_any)
  );

  // A master may present W before AW, so either channel counts as a write request.
  cpu_axi_arb_rr u_wr_rr (
    .i_req   ({inport1_awvalid | inport1_wvalid, inport0_awvalid | inport0_wvalid}),
    .i_last  (r_wr_last),
    .o_grant (w_wr_grant),
    .o_valid (w_wr_any)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_state <= R_IDLE;
      r_rd_owner <= PORT_ICACHE;
      r_rd_last  <= PORT_DCACHE;
    end else begin
      case (r_rd_state)
        R_IDLE: if (w_rd_any) begin
          r_rd_owner <= w_rd_grant;
          r_rd_state <= R_ADDR;
        end
        R_ADDR: if (outport_arvalid && outport_arready) r_rd_state <= R_DATA;
        R_DATA: if (outport_rvalid && outport_rready && outport_rlast) begin
          r_rd_last  <= r_rd_owner;
          r_rd_state <= R_IDLE;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_comb begin
    outport_arvalid = 1'b0;
    outport_araddr  = '0;
    outport_arid    = '0;
    outport_arlen   = '0;
    outport_arburst = '0;
    outport_rready  = 1'b0;
    inport0_arready = 1'b0;
    inport1_arready = 1'b0;
    inport0_rvalid  = 1'b0;
    inport0_rdata   = '0;
    inport0_rresp   = '0;
    inport0_rid     = '0;
    inport0_rlast   = 1'b0;
    inport1_rvalid  = 1'b0;
    inport1_rdata   = '0;
    inport1_rresp   = '0;
    inport1_rid     = '0;
    inport1_rlast   = 1'b0;
    case (r_rd_state)
      R_ADDR: begin
        outport_arvalid = w_own_arvalid;
        outport_araddr  = w_own_araddr;
        outport_arid    = w_own_arid;
        outport_arlen   = w_own_arlen;
        outport_arburst = w_own_arburst;
        if (r_rd_owner == PORT_DCACHE) inport1_arready = outport_arready;
        else                           inport0_arready = outport_arready;
      end
      R_DATA: begin
        outport_rready = w_own_rready;
        if (r_rd_owner == PORT_DCACHE) begin
          inport1_rvalid = outport_rvalid;
          inport1_rdata  = outport_rdata;
          inport1_rresp  = outport_rresp;
          inport1_rid    = outport_rid;
          inport1_rlast  = outport_rlast;
        end else begin
          inport0_rvalid = outport_rvalid;
          inport0_rdata  = outport_rdata;
          inport0_rresp  = outport_rresp;
          inport0_rid    = outport_rid;
          inport0_rlast  = outport_rlast;
        end
      end
      default: ;
    endcase
  end

  assign w_aw_hs     = outport_awvalid && outport_awready;
  assign w_w_last_hs = outport_wvalid && outport_wready && outport_wlast;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_state <= W_IDLE;
      r_wr_owner <= PORT_ICACHE;
      r_wr_last  <= PORT_DCACHE;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: if (w_wr_any) begin
          r_wr_owner <= w_wr_grant;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
          r_wr_state <= W_XFER;
        end
        W_XFER: begin
          if (w_aw_hs)     r_aw_done <= 1'b1;
          if (w_w_last_hs) r_w_done  <= 1'b1;
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_last_hs)) r_wr_state <= W_RESP;
        end
        W_RESP: if (outport_bvalid && outport_bready) begin
          r_wr_last  <= r_wr_owner;
          r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Completed channels are masked so AW and W are each forwarded exactly once.
  always_comb begin
    outport_awvalid = 1'b0;
    outport_awaddr  = '0;
    outport_awid    = '0;
    outport_awlen   = '0;
    outport_awburst = '0;
    outport_wvalid  = 1'b0;
    outport_wdata   = '0;
    outport_wstrb   = '0;
    outport_wlast   = 1'b0;
    outport_bready  = 1'b0;
    inport0_awready = 1'b0;
    inport1_awready = 1'b0;
    inport0_wready  = 1'b0;
    inport1_wready  = 1'b0;
    inport0_bvalid  = 1'b0;
    inport0_bresp   = '0;
    inport0_bid     = '0;
    inport1_bvalid  = 1'b0;
    inport1_bresp   = '0;
    inport1_bid     = '0;
    case (r_wr_state)
      W_XFER: begin
        outport_awvalid = w_own_awvalid && !r_aw_done;
        outport_awaddr  = w_own_awaddr;
        outport_awid    = w_own_awid;
        outport_awlen   = w_own_awlen;
        outport_awburst = w_own_awburst;
        outport_wvalid  = w_own_wvalid && !r_w_done;
        outport_wdata   = w_own_wdata;
        outport_wstrb   = w_own_wstrb;
        outport_wlast   = w_own_wlast;
        if (r_wr_owner == PORT_DCACHE) begin
          inport1_awready = outport_awready && !r_aw_done;
          inport1_wready  = outport_wready && !r_w_done;
        end else begin
          inport0_awready = outport_awready && !r_aw_done;
          inport0_wready  = outport_wready && !r_w_done;
        end
      end
      W_RESP: begin
        outport_bready = w_own_bready;
        if (r_wr_owner == PORT_DCACHE) begin
          inport1_bvalid = outport_bvalid;
          inport1_bresp  = outport_bresp;
          inport1_bid    = outport_bid;
        end else begin
          inport0_bvalid = outport_bvalid;
          inport0_bresp  = outport_bresp;
          inport0_bid    = outport_bid;
        end
      end
      default: ;
    endcase
  end

endmodule
